grey_window_counter: RTL

Parametrised, gated event counter for ring-oscillator and cascaded-counter outputs. It synchronises an asynchronous event line and counts its rising edges in Grey code over a programmable window of clock cycles. At the end of the window it captures the result (Grey and binary), flags wrap-around, and compares the capture against an externally returned value. It replaces the fixed-width, free-running Grey cascade plus separate compare with a single measurement block, fed by the ring-select output.

---
 rtl/grey_pkg.sv | 28 ++
 rtl/sync_edge.sv | 30 +++
 rtl/grey_window_counter.sv | 113 +++++++++++
 3 files changed

// File: rtl/grey_pkg.sv
// Shared types and Grey/binary helpers for the Grey-coded window counter.
// Helpers work on a wide vector; callers zero-extend and truncate to their width.
package grey_pkg;

    localparam int MIN_SYNC = 2;
    localparam int MAX_W    = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Zero-extended inputs give correct results for any width up to MAX_W
    function automatic logic [MAX_W-1:0] bin2grey(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [MAX_W-1:0] grey2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous line plus rising-edge pulse.
// Pulse is high for one cycle when the synchronised line goes 0 -> 1.
module sync_edge
    import grey_pkg::*;
#(
    parameter int DEPTH = MIN_SYNC
) (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic pulse
);

    logic [DEPTH-1:0] chain;
    logic             prev;

    // Shift the async line through the chain and remember the last output
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
            prev  <= 1'b0;
        end else begin
            chain <= {chain[DEPTH-2:0], line};
            prev  <= chain[DEPTH-1];
        end
    end

    assign pulse = chain[DEPTH-1] & ~prev;

endmodule

// File: rtl/grey_window_counter.sv
// Gated Grey-code event counter: counts synchronised rising edges over a
// programmable window, captures Grey/binary result and compares it.
module grey_window_counter
    import grey_pkg::*;
#(
    parameter int pWIDTH    = 10,
    parameter int pWIN_BITS = 8,
    parameter int pSYNC     = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_cnt,
    input  logic                 i_start,
    input  logic [pWIN_BITS-1:0] i_win,
    input  logic [pWIDTH-1:0]    i_ret,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [pWIDTH-1:0]    o_cnt,
    output logic [pWIDTH-1:0]    o_bin,
    output logic                 o_ovf,
    output logic [pWIDTH-1:0]    o_diff
);

    localparam int SYNC_DEPTH = (pSYNC < MIN_SYNC) ? MIN_SYNC : pSYNC;

    logic                 evt;
    state_t               state;
    logic [pWIN_BITS-1:0] win_left;
    logic [pWIDTH-1:0]    run_bin;
    logic                 run_ovf;
    logic [pWIDTH-1:0]    bin_next;
    logic                 ovf_next;

    sync_edge #(
        .DEPTH(SYNC_DEPTH)
    ) u_sync (
        .clk  (i_clk),
        .rst  (i_rst),
        .line (i_cnt),
        .pulse(evt)
    );

    // Next running count including an event in the current cycle
    always_comb begin
        bin_next = run_bin + pWIDTH'(evt);
        ovf_next = run_ovf | (evt & (&run_bin));
    end

    // Window state machine with registered busy/done/capture outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            win_left <= '0;
            run_bin  <= '0;
            run_ovf  <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_cnt    <= '0;
            o_bin    <= '0;
            o_ovf    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_start) begin
                        run_bin <= '0;
                        run_ovf <= 1'b0;
                        if (i_win != '0) begin
                            win_left <= i_win;
                            state    <= MEASURE;
                            o_busy   <= 1'b1;
                        end else begin
                            state  <= DONE;
                            o_done <= 1'b1;
                            o_cnt  <= '0;
                            o_bin  <= '0;
                            o_ovf  <= 1'b0;
                        end
                    end
                end
                MEASURE: begin
                    run_bin  <= bin_next;
                    run_ovf  <= ovf_next;
                    win_left <= win_left - pWIN_BITS'(1);
                    if (win_left == pWIN_BITS'(1)) begin
                        state  <= DONE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                        o_cnt  <= pWIDTH'(bin2grey(MAX_W'(bin_next)));
                        o_bin  <= pWIDTH'(grey2bin(bin2grey(MAX_W'(bin_next))));
                        o_ovf  <= ovf_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Compare captured Grey value against the returned value every cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_diff <= '0;
        end else begin
            o_diff <= o_cnt ^ i_ret;
        end
    end

endmodule
